// File: rtl/dbg_clk_pkg.sv
// Shared definitions for the debug clock controller.
//   MODE_*  : encodings of the 2-bit mode input from the debug switches.
//   state_t : controller FSM states.
//   mode_state() : the FSM state that corresponds to a mode value.
package dbg_clk_pkg;

  localparam logic [1:0] MODE_HALT   = 2'b00;
  localparam logic [1:0] MODE_RUN    = 2'b01;
  localparam logic [1:0] MODE_STEP   = 2'b10;
  localparam logic [1:0] MODE_RUN_BP = 2'b11;

  typedef enum logic [1:0] {
    S_HALT   = 2'b00,
    S_RUN    = 2'b01,
    S_RUN_BP = 2'b10,
    S_BREAK  = 2'b11
  } state_t;

  // HALT and STEP both park the CPU in S_HALT; they differ only in
  // whether step requests are honoured.
  function automatic state_t mode_state(input logic [1:0] m);
    case (m)
      MODE_RUN:    return S_RUN;
      MODE_RUN_BP: return S_RUN_BP;
      default:     return S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running period divider for the CPU clock enable.
// Ports:
//   qzt_clk : system clock
//   reset   : synchronous, active-high
//   en      : count this cycle
//   clear   : force the counter back to 0 (has priority over en)
//   period  : cycles per tick; 0 behaves as 1
//   tick    : combinational terminal-count flag, qualified by en
module tick_divider #(
  parameter int DIV_W = 29
) (
  input  logic             qzt_clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_last;

  assign w_last = (period == '0) ? '0 : period - ONE;

  // ">=" rather than "==" so that shrinking the period below the current
  // count fires on the next cycle instead of waiting for a full wrap.
  assign tick = en && (r_cnt >= w_last);

  always_ff @(posedge qzt_clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + ONE;
    end
  end

endmodule

// File: rtl/dbg_clock_controller.sv
// CPU clock-enable generator with halt, free-run, single-step and
// run-to-breakpoint modes. Produces a one-cycle cpu_tick enable in the
// qzt_clk domain and reports status for the LCD debug path.
// Ports:
//   qzt_clk, reset : clock and synchronous active-high reset
//   mode           : 00 HALT, 01 RUN, 10 STEP, 11 RUN_BP
//   period         : qzt_clk cycles per tick in RUN/RUN_BP (0 acts as 1)
//   step_req       : single-cycle step pulse
//   bp_addr        : breakpoint address
//   cpu_addr       : current CPU fetch address
//   cpu_tick       : registered one-cycle clock enable
//   halted         : 1 in S_HALT / S_BREAK
//   bp_hit         : sticky breakpoint flag
//   tick_count     : ticks issued since reset, wrapping
module dbg_clock_controller
  import dbg_clk_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DIV_W  = 29,
  parameter int CNT_W  = 16
) (
  input  logic              qzt_clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  period,
  input  logic              step_req,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_tick,
  output logic              halted,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  tick_count
);

  state_t           r_state;
  logic [1:0]       r_mode;
  logic             r_first;
  logic             r_cpu_tick;
  logic             r_halted;
  logic             r_bp_hit;
  logic [CNT_W-1:0] r_tick_count;

  state_t w_state_nxt;
  logic   w_mode_chg;
  logic   w_div_en;
  logic   w_div_tick;
  logic   w_bp_match;
  logic   w_step;
  logic   w_tick;

  // A mode change is detected against the mode sampled on the previous
  // edge; during that cycle the divider is held clear and steps are
  // dropped, so the new mode always starts from a clean counter.
  assign w_mode_chg = (mode != r_mode);
  assign w_div_en   = ((r_state == S_RUN) || (r_state == S_RUN_BP)) && !w_mode_chg;

  tick_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .qzt_clk (qzt_clk),
    .reset   (reset),
    .en      (w_div_en),
    .clear   (!w_div_en),
    .period  (period),
    .tick    (w_div_tick)
  );

  // r_first exempts the first tick after entering RUN_BP, so resuming from
  // the breakpoint address does not immediately re-break.
  assign w_bp_match = w_div_tick && (r_state == S_RUN_BP) && !r_first &&
                      (cpu_addr == bp_addr);

  assign w_step = step_req && !w_mode_chg &&
                  (((r_state == S_HALT) && (r_mode == MODE_STEP)) ||
                   (r_state == S_BREAK));

  assign w_tick = (w_div_tick && !w_bp_match) || w_step;

  always_comb begin
    w_state_nxt = r_state;
    if (w_mode_chg) begin
      w_state_nxt = mode_state(mode);
    end else if (w_bp_match) begin
      w_state_nxt = S_BREAK;
    end
  end

  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      r_state      <= S_HALT;
      r_mode       <= MODE_HALT;
      r_first      <= 1'b0;
      r_cpu_tick   <= 1'b0;
      r_halted     <= 1'b1;
      r_bp_hit     <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode     <= mode;
      r_cpu_tick <= w_tick;
      r_halted   <= (w_state_nxt == S_HALT) || (w_state_nxt == S_BREAK);

      if (w_mode_chg) begin
        r_first <= 1'b1;
      end else if (w_div_tick) begin
        r_first <= 1'b0;
      end

      // Stepping inside S_BREAK leaves the flag alone; only leaving
      // RUN_BP mode clears it.
      if (w_mode_chg && (mode != MODE_RUN_BP)) begin
        r_bp_hit <= 1'b0;
      end else if (w_bp_match) begin
        r_bp_hit <= 1'b1;
      end

      if (w_tick) begin
        r_tick_count <= r_tick_count + CNT_W'(1);
      end
    end
  end

  assign cpu_tick   = r_cpu_tick;
  assign halted     = r_halted;
  assign bp_hit     = r_bp_hit;
  assign tick_count = r_tick_count;

endmodule
